// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM states, op-class helpers.
// Optional accumulate ops are enabled by defining MD_UNIT_MADD_EN.
package md_pkg;

  localparam logic [3:0] MD_NOP   = 4'd0;
  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MTHI  = 4'd5;
  localparam logic [3:0] MD_MTLO  = 4'd6;
  localparam logic [3:0] MD_MFHI  = 4'd7;
  localparam logic [3:0] MD_MFLO  = 4'd8;
  localparam logic [3:0] MD_MADD  = 4'd9;
  localparam logic [3:0] MD_MADDU = 4'd10;
  localparam logic [3:0] MD_MSUB  = 4'd11;
  localparam logic [3:0] MD_MSUBU = 4'd12;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_RUN  = 1'b1
  } md_state_t;

  // Ops that occupy the unit for multiple cycles.
  function automatic logic is_md_busy_op(input logic [3:0] op);
    case (op)
      MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: return 1'b1;
`ifdef MD_UNIT_MADD_EN
      MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic is_md_div_op(input logic [3:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_unit_calc.sv
// Combinational HI/LO result datapath: products, quotients/remainders and optional accumulate.
// Accumulate ops (MADD/MADDU/MSUB/MSUBU) exist only when MD_UNIT_MADD_EN is defined.
module md_calc
  import md_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi_nx,
  output logic [WIDTH-1:0] lo_nx,
  output logic             div0
);

  localparam int W2 = 2 * WIDTH;
  localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};

  logic signed [W2-1:0]    rs_sx, rt_sx;
  logic        [W2-1:0]    prod_s, prod_u;
  logic                    ovf;
  logic        [WIDTH-1:0] rt_s, rt_u;
  logic signed [WIDTH-1:0] sq, sr;
  logic        [WIDTH-1:0] uq, ur;

  assign rs_sx  = {{WIDTH{rs[WIDTH-1]}}, rs};
  assign rt_sx  = {{WIDTH{rt[WIDTH-1]}}, rt};
  assign prod_s = rs_sx * rt_sx;
  assign prod_u = {{WIDTH{1'b0}}, rs} * {{WIDTH{1'b0}}, rt};

  assign div0 = is_md_div_op(op) && (rt == '0);
  assign ovf  = (rs == MIN_INT) && (rt == '1);

  // Divisors are forced to 1 in the zero/overflow cases so the dividers never
  // see an undefined operation; those results are overridden below anyway.
  assign rt_s = (div0 || ovf) ? WIDTH'(1) : rt;
  assign rt_u = div0 ? WIDTH'(1) : rt;
  assign sq   = $signed(rs) / $signed(rt_s);
  assign sr   = $signed(rs) % $signed(rt_s);
  assign uq   = rs / rt_u;
  assign ur   = rs % rt_u;

  always_comb begin
    hi_nx = hi;
    lo_nx = lo;
    case (op)
      MD_MULT:  {hi_nx, lo_nx} = prod_s;
      MD_MULTU: {hi_nx, lo_nx} = prod_u;
      MD_DIV: begin
        if (!div0) begin
          if (ovf) begin
            lo_nx = MIN_INT;
            hi_nx = '0;
          end else begin
            lo_nx = sq;
            hi_nx = sr;
          end
        end
      end
      MD_DIVU: begin
        if (!div0) begin
          lo_nx = uq;
          hi_nx = ur;
        end
      end
`ifdef MD_UNIT_MADD_EN
      MD_MADD:  {hi_nx, lo_nx} = {hi, lo} + prod_s;
      MD_MADDU: {hi_nx, lo_nx} = {hi, lo} + prod_u;
      MD_MSUB:  {hi_nx, lo_nx} = {hi, lo} - prod_s;
      MD_MSUBU: {hi_nx, lo_nx} = {hi, lo} - prod_u;
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// Multiply/divide unit: owns HI/LO, sequences multi-cycle mult/div, services mthi/mtlo/mfhi/mflo.
// Define MD_UNIT_MADD_EN to add the MADD/MADDU/MSUB/MSUBU accumulate ops.
module md_unit
  import md_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       md_op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             rd_sel,
  output logic [WIDTH-1:0] rd_data,
  output logic             busy,
  output logic             pending,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  md_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_d;
  logic [WIDTH-1:0] hi_d, lo_d;
  logic [WIDTH-1:0] hi_nx, lo_nx, hi_nx_d, lo_nx_d;
  logic             commit_q, commit_d;
  logic [WIDTH-1:0] calc_hi, calc_lo;
  logic             div0;

  md_calc #(.WIDTH(WIDTH)) u_calc (
    .op    (md_op),
    .rs    (rs_data),
    .rt    (rt_data),
    .hi    (hi),
    .lo    (lo),
    .hi_nx (calc_hi),
    .lo_nx (calc_lo),
    .div0  (div0)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= MD_IDLE;
      cnt_q    <= '0;
      busy     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      hi_nx    <= '0;
      lo_nx    <= '0;
      commit_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      busy     <= busy_d;
      hi       <= hi_d;
      lo       <= lo_d;
      hi_nx    <= hi_nx_d;
      lo_nx    <= lo_nx_d;
      commit_q <= commit_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    busy_d   = busy;
    hi_d     = hi;
    lo_d     = lo;
    hi_nx_d  = hi_nx;
    lo_nx_d  = lo_nx;
    commit_d = commit_q;
    case (state_q)
      MD_IDLE: begin
        if (start) begin
          if (is_md_busy_op(md_op)) begin
            hi_nx_d  = calc_hi;
            lo_nx_d  = calc_lo;
            commit_d = !div0;
            cnt_d    = is_md_div_op(md_op) ? DIV_LOAD : MULT_LOAD;
            busy_d   = 1'b1;
            state_d  = MD_RUN;
          end else if (md_op == MD_MTHI) begin
            hi_d = rs_data;
          end else if (md_op == MD_MTLO) begin
            lo_d = rs_data;
          end
        end
      end
      MD_RUN: begin
        // start is deliberately not examined here; the stall unit holds upstream on pending.
        if (cnt_q == '0) begin
          if (commit_q) begin
            hi_d = hi_nx;
            lo_d = lo_nx;
          end
          busy_d  = 1'b0;
          state_d = MD_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = MD_IDLE;
    endcase
  end

  assign rd_data = rd_sel ? hi : lo;
  assign pending = busy | (start & is_md_busy_op(md_op));

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed scenarios plus random ops against a behavioural model.
module tb_md_unit;

  localparam int WIDTH = 32;
  localparam int MC    = 5;
  localparam int DC    = 10;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [3:0]       md_op;
  logic [WIDTH-1:0] rs_data, rt_data;
  logic             rd_sel;
  logic [WIDTH-1:0] rd_data, hi, lo;
  logic             busy, pending;

  int n_cmp  = 0;
  int n_fail = 0;

  md_unit #(.WIDTH(WIDTH), .MULT_CYCLES(MC), .DIV_CYCLES(DC), .CNT_W(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .md_op   (md_op),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .rd_sel  (rd_sel),
    .rd_data (rd_data),
    .busy    (busy),
    .pending (pending),
    .hi      (hi),
    .lo      (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_hi = '0, m_lo = '0, m_rhi = '0, m_rlo = '0;
  int          m_left = 0;
  bit          m_commit = 0;

  function automatic bit mclass(input logic [3:0] op);
    if (op >= 4'd1 && op <= 4'd4) return 1;
`ifdef MD_UNIT_MADD_EN
    if (op >= 4'd9 && op <= 4'd12) return 1;
`endif
    return 0;
  endfunction

  task automatic model_start();
    longint          sa, sb;
    logic [63:0]     p, acc;
    sa = $signed(rs_data);
    sb = $signed(rt_data);
    m_commit = 1;
    case (md_op)
      4'd1: {m_rhi, m_rlo} = sa * sb;
      4'd2: {m_rhi, m_rlo} = {32'd0, rs_data} * {32'd0, rt_data};
      4'd3: begin
        if (rt_data == 0) m_commit = 0;
        else begin
          p = sa / sb;
          acc = sa % sb;
          m_rlo = p[31:0];
          m_rhi = acc[31:0];
        end
      end
      4'd4: begin
        if (rt_data == 0) m_commit = 0;
        else begin
          m_rlo = rs_data / rt_data;
          m_rhi = rs_data % rt_data;
        end
      end
`ifdef MD_UNIT_MADD_EN
      4'd9, 4'd10, 4'd11, 4'd12: begin
        if (md_op == 4'd9 || md_op == 4'd11) p = sa * sb;
        else p = {32'd0, rs_data} * {32'd0, rt_data};
        acc = {m_hi, m_lo};
        acc = (md_op <= 4'd10) ? acc + p : acc - p;
        {m_rhi, m_rlo} = acc;
      end
`endif
      default: ;
    endcase
    m_left = (md_op == 4'd3 || md_op == 4'd4) ? DC : MC;
  endtask

  always @(posedge clk) begin
    if (reset) begin
      m_hi = '0; m_lo = '0; m_left = 0; m_commit = 0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0 && m_commit) begin
        m_hi = m_rhi;
        m_lo = m_rlo;
      end
    end else if (start) begin
      if (mclass(md_op)) model_start();
      else if (md_op == 4'd5) m_hi = rs_data;
      else if (md_op == 4'd6) m_lo = rs_data;
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      check("busy",    {31'd0, busy},    {31'd0, m_left > 0});
      check("hi",      hi, m_hi);
      check("lo",      lo, m_lo);
      check("rd_data", rd_data, rd_sel ? m_hi : m_lo);
      check("pending", {31'd0, pending},
            {31'd0, (m_left > 0) || (start && mclass(md_op))});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; md_op = op; rs_data = a; rt_data = b;
    @(posedge clk); #1;
    start = 1'b0; md_op = 4'd0;
  endtask

  task automatic count_busy(input string name, input int exp);
    int c = 0;
    while (busy === 1'b1 && c < 60) begin
      c++;
      @(posedge clk); #1;
    end
    check(name, c, exp);
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy !== 1'b0 && k < 60) begin
      @(posedge clk); #1;
      k++;
    end
    if (k >= 60) begin
      n_cmp++; n_fail++;
      $display("FAIL idle_timeout: busy=%b expected 0", busy);
    end
  endtask

  function automatic logic [31:0] rnd_word();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    reset = 1'b1; start = 1'b0; md_op = '0; rs_data = '0; rt_data = '0; rd_sel = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_hi", hi, 32'h0);
    check("reset_lo", lo, 32'h0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // MULT -3 * 7 with pending in the start cycle
    start = 1'b1; md_op = 4'd1; rs_data = 32'hFFFF_FFFD; rt_data = 32'd7;
    #1 check("pending_start", {31'd0, pending}, 32'd1);
    @(posedge clk); #1;
    start = 1'b0; md_op = 4'd0;
    count_busy("mult_busy_cycles", MC);
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFEB);

    issue(4'd3, 32'hFFFF_FFF9, 32'd2);
    count_busy("div_busy_cycles", DC);
    check("div_lo", lo, 32'hFFFF_FFFD);
    check("div_hi", hi, 32'hFFFF_FFFF);

    issue(4'd4, 32'd7, 32'd2);
    wait_idle();
    check("divu_lo", lo, 32'd3);
    check("divu_hi", hi, 32'd1);

    issue(4'd5, 32'h11, 32'd0);
    issue(4'd6, 32'h22, 32'd0);
    issue(4'd3, 32'd1234, 32'd0);
    count_busy("div0_busy_cycles", DC);
    check("div0_hi", hi, 32'h11);
    check("div0_lo", lo, 32'h22);

    issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle();
    check("divovf_lo", lo, 32'h8000_0000);
    check("divovf_hi", hi, 32'h0);

    // MTLO during busy must be ignored
    rd_sel = 1'b0;
    issue(4'd2, 32'h0001_2345, 32'h100);
    @(posedge clk); #1;
    issue(4'd6, 32'h55, 32'd0);
    wait_idle();
    check("multu_lo", lo, 32'h0123_4500);
    check("multu_rd", rd_data, 32'h0123_4500);

    // reset on the third busy cycle of a DIV
    issue(4'd3, 32'd100, 32'd7);
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_hi", hi, 32'h0);
    check("abort_lo", lo, 32'h0);
    issue(4'd1, 32'd6, 32'd7);
    wait_idle();
    check("after_abort_lo", lo, 32'd42);

`ifdef MD_UNIT_MADD_EN
    issue(4'd5, 32'h0, 32'd0);
    issue(4'd6, 32'hFFFF_FFFF, 32'd0);
    issue(4'd10, 32'd1, 32'd1);
    count_busy("maddu_busy_cycles", MC);
    check("maddu_hi", hi, 32'd1);
    check("maddu_lo", lo, 32'd0);
`endif

    // random phase
    for (int i = 0; i < 600; i++) begin
      start   = ($urandom_range(0, 2) == 0);
      md_op   = 4'($urandom_range(0, 13));
      rs_data = rnd_word();
      rt_data = rnd_word();
      rd_sel  = 1'($urandom_range(0, 1));
      reset   = ($urandom_range(0, 199) == 0);
      @(posedge clk); #1;
    end
    start = 1'b0; reset = 1'b0; md_op = '0;
    wait_idle();
    @(posedge clk); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
